// File: rtl/arbitro_rr.sv
// Round-robin mover: pops one non-empty source FIFO per cycle and pushes the word one cycle later
// to the destination FIFO named by its dest field. Define ARB_BURST_EN for burst-limited grants.
module arbitro_rr #(
  parameter int DATA_WIDTH = 6,
  parameter int DEST_LSB   = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            empty_naranja,
  input  logic [3:0]            almost_full,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [3:0]            pop,
  output logic [3:0]            push,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            grant,
  output logic [3:0]            state,
  output logic                  idle
);

  typedef enum logic [3:0] {
    ST_RESET  = 4'b0001,
    ST_INIT   = 4'b0010,
    ST_IDLE   = 4'b0100,
    ST_ACTIVE = 4'b1000
  } state_t;

  if (BURST_LEN < 1) begin : g_bad_burst
    $error("BURST_LEN must be at least 1");
  end

  state_t                st_q;
  logic [1:0]            ptr_q;
  logic [1:0]            ptr_nxt;
  logic [3:0]            push_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [1:0]            sel;
  logic                  sel_vld;
  logic                  stall;
  logic                  pop_en;

  function automatic logic [3:0] dec2(input logic [1:0] idx);
    dec2 = 4'b0001 << idx;
  endfunction

  // Descending scan so the source closest to ptr (offset 0) is the one that sticks.
  always_comb begin
    sel     = ptr_q;
    sel_vld = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (!empty_naranja[ptr_q + 2'(k)]) begin
        sel     = ptr_q + 2'(k);
        sel_vld = 1'b1;
      end
    end
  end

  assign stall  = |almost_full;
  assign pop_en = (st_q == ST_ACTIVE) && !stall && !reset && !init && sel_vld;

  assign pop      = pop_en ? dec2(sel) : 4'b0000;
  assign grant    = pop_en ? sel : 2'd0;
  assign state    = st_q;
  assign push     = push_p0;
  assign data_out = data_p0;
  assign idle     = (st_q == ST_IDLE) && (&empty_naranja) && (push_p0 == 4'b0000);

`ifdef ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  logic [CNT_W-1:0] burst_q;
  logic [CNT_W-1:0] burst_nxt;
  logic [1:0]       last_q;

  // Pointer parks on the granted source until it has had BURST_LEN pops in a row.
  always_comb begin
    burst_nxt = ((sel == last_q) && (burst_q != '0)) ? burst_q + 1'b1 : CNT_W'(1);
    ptr_nxt   = sel;
    if (int'(burst_nxt) >= BURST_LEN) begin
      ptr_nxt   = sel + 2'd1;
      burst_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_q <= '0;
      last_q  <= 2'd0;
    end else if (stall) begin
      burst_q <= '0;
    end else if (pop_en) begin
      burst_q <= burst_nxt;
      last_q  <= sel;
    end
  end
`else
  assign ptr_nxt = sel + 2'd1;
`endif

  // Stage p0: word popped this cycle is registered and pushed next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q    <= ST_RESET;
      ptr_q   <= 2'd0;
      push_p0 <= 4'b0000;
      data_p0 <= '0;
    end else begin
      push_p0 <= pop_en ? dec2(data_in[DEST_LSB +: 2]) : 4'b0000;
      if (pop_en) begin
        data_p0 <= data_in;
        ptr_q   <= ptr_nxt;
      end
      case (st_q)
        ST_RESET:  st_q <= ST_INIT;
        ST_INIT:   if (!init) st_q <= ST_IDLE;
        ST_IDLE: begin
          if (init) st_q <= ST_INIT;
          else if (!(&empty_naranja) && !stall) st_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init) st_q <= ST_INIT;
          else if ((&empty_naranja) || stall) st_q <= ST_IDLE;
        end
        default:   st_q <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr.sv
// Directed bench for arbitro_rr (default build): reset/init sequencing, round robin,
// single-source streaming, almost_full stall/resume, reset with a word in flight, init priority.
module tb_arbitro_rr;

  logic       clk = 1'b0;
  logic       reset, init;
  logic [3:0] empty_naranja, almost_full;
  logic [5:0] data_in;
  logic [3:0] pop, push, state;
  logic [5:0] data_out;
  logic [1:0] grant;
  logic       idle;

  logic [5:0] heads [4];
  int n_cmp = 0;
  int n_bad = 0;

  // Source FIFO heads: {dest, payload}
  localparam logic [5:0] H0 = 6'b10_0001;
  localparam logic [5:0] H1 = 6'b11_0010;
  localparam logic [5:0] H2 = 6'b00_0011;
  localparam logic [5:0] H3 = 6'b01_0100;

  arbitro_rr #(.DATA_WIDTH(6), .DEST_LSB(4), .BURST_LEN(4)) dut (
    .clk(clk), .reset(reset), .init(init),
    .empty_naranja(empty_naranja), .almost_full(almost_full),
    .data_in(data_in), .pop(pop), .push(push), .data_out(data_out),
    .grant(grant), .state(state), .idle(idle)
  );

  always #5 clk = ~clk;
  assign data_in = heads[grant];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] exp_st [3];
    exp_st = '{4'b0001, 4'b0010, 4'b0010};
    reset = 1'b1; init = 1'b0; empty_naranja = 4'hF; almost_full = 4'h0;
    heads[0] = H0; heads[1] = H1; heads[2] = H2; heads[3] = H3;
    tick; tick; #1;
    n_cmp++; if (state !== 4'b0001) begin n_bad++; $display("FAIL reset_state: got %b want 0001", state); end
    n_cmp++; if ({pop, push, grant, idle} !== 11'd0) begin n_bad++; $display("FAIL reset_outs: pop %b push %b grant %0d idle %b want all 0", pop, push, grant, idle); end
    n_cmp++; if (data_out !== 6'd0) begin n_bad++; $display("FAIL reset_data: got %h want 00", data_out); end
    reset = 1'b0; init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (state !== exp_st[i]) begin n_bad++; $display("FAIL init_state c%0d: got %b want %b", i, state, exp_st[i]); end
      tick;
    end
    init = 1'b0; #1;
    n_cmp++; if (state !== 4'b0010) begin n_bad++; $display("FAIL init_hold: got %b want 0010", state); end
    tick; #1;
    n_cmp++; if (state !== 4'b0100) begin n_bad++; $display("FAIL init_to_idle: got %b want 0100", state); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL idle_empty: got %b want 1", idle); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_pop [7];
    logic [3:0] exp_push [7];
    logic [1:0] exp_gnt [7];
    logic [5:0] exp_do [7];
    exp_pop  = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_push = '{4'b0000, 4'b0000, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
    exp_gnt  = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_do   = '{6'd0, 6'd0, H0, H1, H2, H3, H0};
    empty_naranja = 4'h0;
    for (int k = 0; k < 7; k++) begin
      #1;
      n_cmp++; if (pop !== exp_pop[k]) begin n_bad++; $display("FAIL rr_pop c%0d: got %b want %b", k, pop, exp_pop[k]); end
      n_cmp++; if (grant !== exp_gnt[k]) begin n_bad++; $display("FAIL rr_grant c%0d: got %0d want %0d", k, grant, exp_gnt[k]); end
      if (k >= 2) begin
        n_cmp++; if (push !== exp_push[k]) begin n_bad++; $display("FAIL rr_push c%0d: got %b want %b", k, push, exp_push[k]); end
        n_cmp++; if (data_out !== exp_do[k]) begin n_bad++; $display("FAIL rr_data c%0d: got %h want %h", k, data_out, exp_do[k]); end
      end
      tick;
    end
    empty_naranja = 4'hF; #1;
    n_cmp++; if (pop !== 4'b0000) begin n_bad++; $display("FAIL rr_empty_pop: got %b want 0000", pop); end
    n_cmp++; if (push !== 4'b1000 || data_out !== H1) begin n_bad++; $display("FAIL rr_last_push: got %b/%h want 1000/%h", push, data_out, H1); end
    tick; #1;
    n_cmp++; if (push !== 4'b0000) begin n_bad++; $display("FAIL rr_no_push: got %b want 0000", push); end
    n_cmp++; if (state !== 4'b0100 || idle !== 1'b1) begin n_bad++; $display("FAIL rr_back_idle: state %b idle %b want 0100/1", state, idle); end
  endtask

  task automatic test_single_source;
    empty_naranja = 4'b1011;
    for (int k = 0; k < 5; k++) begin
      heads[2] = {2'b11, 4'(k)};
      #1;
      if (k >= 1) begin
        n_cmp++; if (pop !== 4'b0100 || grant !== 2'd2) begin n_bad++; $display("FAIL ss_pop c%0d: got %b/%0d want 0100/2", k, pop, grant); end
      end
      if (k >= 2) begin
        n_cmp++; if (push !== 4'b1000) begin n_bad++; $display("FAIL ss_push c%0d: got %b want 1000", k, push); end
        n_cmp++; if (data_out !== {2'b11, 4'(k - 1)}) begin n_bad++; $display("FAIL ss_data c%0d: got %h want %h", k, data_out, {2'b11, 4'(k - 1)}); end
      end
      tick;
    end
    empty_naranja = 4'hF; #1;
    n_cmp++; if (pop !== 4'b0000 || push !== 4'b1000 || data_out !== 6'b11_0100) begin n_bad++; $display("FAIL ss_drain: pop %b push %b data %h want 0000/1000/34", pop, push, data_out); end
    tick;
    heads[2] = H2;
  endtask

  task automatic test_backpressure;
    logic [3:0] af_t [9];
    logic [3:0] emp_t [9];
    logic [3:0] exp_pop [9];
    logic [3:0] exp_push [9];
    af_t     = '{4'h0, 4'h0, 4'h0, 4'b0010, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0};
    emp_t    = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
    exp_pop  = '{4'b0000, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000};
    exp_push = '{4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001};
    for (int k = 0; k < 9; k++) begin
      almost_full = af_t[k]; empty_naranja = emp_t[k];
      #1;
      n_cmp++; if (pop !== exp_pop[k]) begin n_bad++; $display("FAIL bp_pop c%0d: got %b want %b", k, pop, exp_pop[k]); end
      n_cmp++; if (push !== exp_push[k]) begin n_bad++; $display("FAIL bp_push c%0d: got %b want %b", k, push, exp_push[k]); end
      if (k == 4) begin
        n_cmp++; if (state !== 4'b0100) begin n_bad++; $display("FAIL bp_stall_state: got %b want 0100", state); end
      end
      tick;
    end
  endtask

  task automatic test_reset_inflight;
    logic [3:0] emp_t [10];
    logic       rst_t [10];
    logic       ini_t [10];
    logic [3:0] exp_pop [10];
    logic [3:0] exp_push [10];
    logic [3:0] exp_st [10];
    emp_t    = '{4'b1101, 4'b1101, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    rst_t    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    ini_t    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    exp_pop  = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    exp_push = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};
    exp_st   = '{4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000, 4'b0010, 4'b0001};
    for (int k = 0; k < 10; k++) begin
      empty_naranja = emp_t[k]; reset = rst_t[k]; init = ini_t[k];
      #1;
      n_cmp++; if (state !== exp_st[k]) begin n_bad++; $display("FAIL rf_state c%0d: got %b want %b", k, state, exp_st[k]); end
      n_cmp++; if (pop !== exp_pop[k]) begin n_bad++; $display("FAIL rf_pop c%0d: got %b want %b", k, pop, exp_pop[k]); end
      n_cmp++; if (push !== exp_push[k]) begin n_bad++; $display("FAIL rf_push c%0d: got %b want %b", k, push, exp_push[k]); end
      if (k == 3) begin
        n_cmp++; if (data_out !== 6'd0) begin n_bad++; $display("FAIL rf_data_cleared: got %h want 00", data_out); end
      end
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single_source;
    test_backpressure;
    test_reset_inflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
